serial_mag_compare_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit unsigned magnitude comparison by walking both operands MSB-first through the team's existing 1-bit comparator, one bit per clock. It stops at the first unequal bit. It sits between a requester issuing start/operand pairs and a single shared 1-bit comparator instance, which is external and purely combinational. It returns a one-hot greater/equal/less result, a bits-examined count and an error flag.

---
 rtl/serial_mag_compare_ctrl.sv | 160 ++++++++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare_ctrl.sv
// Serial MSB-first unsigned magnitude compare sequencer.
// Presents one bit pair per cycle to a shared external combinational 1-bit
// comparator and stops at the first unequal bit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; results of last compare held
// S_COMPARE | bit pair a_q[idx_q]/b_q[idx_q] driven to comparator
// S_DONE    | one-cycle done pulse, results valid
module serial_mag_compare_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             A_great_B,
  output logic             A_equal_B,
  output logic             A_less_B,
  output logic [CW-1:0]    bits_used,
  output logic             cmp_err
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;
  logic [CW-1:0]    used_q, used_d;
  logic             cmp_one_hot;
  logic [CW-1:0]    used_now;

  // Valid comparator codes are exactly gt, eq or lt alone.
  assign cmp_one_hot = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                       ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                       ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);

  // Bits examined so far including the one currently presented.
  assign used_now = CW'(WIDTH - int'(idx_q));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IDX_MSB;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
      used_q  <= used_d;
    end
  end

  // Next-state and result update; results only change on accept or termination.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;
    used_d  = used_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IDX_MSB;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          used_d  = '0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!cmp_one_hot) begin
          err_d   = 1'b1;
          used_d  = used_now;
          state_d = S_DONE;
        end else if (cmp_gt) begin
          gt_d    = 1'b1;
          used_d  = used_now;
          state_d = S_DONE;
        end else if (cmp_lt) begin
          lt_d    = 1'b1;
          used_d  = used_now;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          used_d  = used_now;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Comparator bits are only driven while comparing, zero otherwise.
  always_comb begin
    bit_a = 1'b0;
    bit_b = 1'b0;
    if (state_q == S_COMPARE) begin
      bit_a = a_q[idx_q];
      bit_b = b_q[idx_q];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign A_great_B = gt_q;
  assign A_equal_B = eq_q;
  assign A_less_B  = lt_q;
  assign bits_used = used_q;
  assign cmp_err   = err_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Scoreboard bench for serial_mag_compare_ctrl: driver pushes expected
// results at accept time, a negedge monitor pops and compares on done.
module tb_serial_mag_compare_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          bit_a, bit_b;
  logic          cmp_gt, cmp_eq, cmp_lt;
  logic          busy, done;
  logic          A_great_B, A_equal_B, A_less_B;
  logic [CW-1:0] bits_used;
  logic          cmp_err;
  logic          force_err = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           k;
    logic         gt, eq, lt, err;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  serial_mag_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .bit_a(bit_a), .bit_b(bit_b),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .busy(busy), .done(done),
    .A_great_B(A_great_B), .A_equal_B(A_equal_B), .A_less_B(A_less_B),
    .bits_used(bits_used), .cmp_err(cmp_err)
  );

  // External 1-bit comparator; force_err makes it return gt and lt together.
  always_comb begin
    cmp_gt = (bit_a & ~bit_b) | force_err;
    cmp_lt = (~bit_a & bit_b) | force_err;
    cmp_eq = (bit_a == bit_b) & ~force_err;
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: scan for the first differing bit from the top, result from plain
  // arithmetic compare; a forced comparator fault at bit n ends the compare there.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input int errbit);
    exp_t e;
    int   first;
    first = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        first = W - i;
        break;
      end
    end
    e.a = a; e.b = b; e.acc = 0;
    e.k   = first;
    e.gt  = (a > b);
    e.eq  = (a == b);
    e.lt  = (a < b);
    e.err = 1'b0;
    if (errbit > 0 && errbit <= first) begin
      e.k = errbit; e.err = 1'b1;
      e.gt = 1'b0; e.eq = 1'b0; e.lt = 1'b0;
    end
    return e;
  endfunction

  // Monitor: bit tracking during compare, scoreboard pop on done.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("busy_after_done", int'(busy), 0);
      if (busy && !done && exp_q.size() > 0) begin
        int j;
        j = cyc - exp_q[0].acc;
        if (j >= 0 && j < W) begin
          check("bit_a_track", int'(bit_a), int'(exp_q[0].a[W-1-j]));
          check("bit_b_track", int'(bit_b), int'(exp_q[0].b[W-1-j]));
        end
      end else if (!busy || done) begin
        check("bits_idle_zero", int'({bit_a, bit_b}), 0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", cyc - e.acc, e.k);
          check("results_gel", int'({A_great_B, A_equal_B, A_less_B}),
                int'({e.gt, e.eq, e.lt}));
          check("cmp_err", int'(cmp_err), int'(e.err));
          check("bits_used", int'(bits_used), e.k);
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1) begin
      @(negedge clk); #1;
      n++;
      if (n > 100) begin
        check("wait_idle_timeout", n, 0);
        return;
      end
    end
  endtask

  // Issue one compare; returns one cycle after the accept edge (or after the
  // injected fault cycle). With hold=1 start stays high for a back-to-back accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int errbit, input bit hold);
    exp_t e;
    wait_idle();
    A = a; B = b; start = 1'b1;
    e = ref_model(a, b, errbit);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk); #1;
    if (!hold) start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    if (errbit > 0) begin
      repeat (errbit - 1) begin @(negedge clk); #1; end
      force_err = 1'b1;
      @(negedge clk); #1;
      force_err = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    wait_idle();
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    @(negedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_results", int'({A_great_B, A_equal_B, A_less_B, cmp_err}), 0);
    check("rst_bits_used", int'(bits_used), 0);
    check("rst_bits", int'({bit_a, bit_b}), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); #1; end

    // Directed cases.
    issue(8'h80, 8'h7F, 0, 1'b0);
    check("busy_cycle2", int'(busy), 1);
    issue(8'h5A, 8'h5A, 0, 1'b0);
    issue(8'h12, 8'h13, 0, 1'b1);
    issue(8'h00, 8'hFF, 0, 1'b0);

    // Start pulsed mid-compare with other operands must be ignored.
    issue(8'h33, 8'h35, 0, 1'b0);
    @(negedge clk); #1;
    A = 8'hFF; B = 8'h00; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    drain();

    // Reset during the fourth compare cycle discards the result.
    issue(8'h5A, 8'h5A, 0, 1'b0);
    repeat (3) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_results", int'({A_great_B, A_equal_B, A_less_B, cmp_err}), 0);
    check("midrst_bits_used", int'(bits_used), 0);
    check("midrst_bits", int'({bit_a, bit_b}), 0);
    exp_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    issue(8'hC3, 8'hC1, 0, 1'b0);

    // Comparator fault on the third bit.
    issue(8'h5A, 8'h5A, 3, 1'b0);
    drain();

    // Randomized traffic: shared prefixes, back-to-back holds, occasional faults.
    for (int t = 0; t < 300; t++) begin
      logic [W-1:0] a, b;
      exp_t         probe;
      int           eb;
      bit           hold;
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ W'(1 << $urandom_range(0, W - 1));
        default: b = W'($urandom);
      endcase
      probe = ref_model(a, b, 0);
      eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, probe.k)) : 0;
      hold = ($urandom_range(0, 2) == 0);
      issue(a, b, eb, hold);
      if (!hold) repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
    end
    start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
